picoblaze_port_bank: RTL and testbench
======================================

// Module: picoblaze_port_bank
// PURPOSE
//  Parametrised PicoBlaze I/O port bank: NUM_REGS read/write data registers, a sticky button-event
//  register, a status register and a commit handshake toward the RTC controller. Sits between the
//  kcpsm6 port bus and the RTC/display logic. Replaces the fixed 9-register RTC bank and the separate
//  keyboard register/in_port mux with one block.
// PARAMETERS
//  NUM_REGS   9      number of data registers (1..16)
//  DATA_W     8      register width (must equal port width, 8)
//  BASE_ADDR  8'h10  port_id of data register 0; register i at BASE_ADDR+i
//  BTN_N      4      number of button inputs (1..8)
//  BTN_ADDR   8'h01  port_id of button-event register (read, clear-on-read)
//  STAT_ADDR  8'h02  port_id of status register (read)
//  CTRL_ADDR  8'h03  port_id of control register (write)
// PORTS
//  clk           in   1                  system clock
//  reset         in   1                  synchronous, active-high reset
//  port_id       in   8                  kcpsm6 port address
//  write_strobe  in   1                  kcpsm6 write strobe
//  read_strobe   in   1                  kcpsm6 read strobe
//  out_port      in   8                  kcpsm6 write data
//  in_port       out  8                  kcpsm6 read data (registered)
//  btn           in   BTN_N              raw asynchronous buttons (active-high)
//  ext_load      in   1                  1-cycle pulse: load all regs from ext_data (RTC read done)
//  ext_data      in   NUM_REGS*DATA_W    RTC values, reg i at [i*8+:8]
//  reg_data      out  NUM_REGS*DATA_W    current register contents, reg i at [i*8+:8]
//  reg_we        out  NUM_REGS           one-hot 1-cycle pulse: CPU wrote reg i
//  commit_req    out  1                  request RTC to write reg_data
//  commit_ack    in   1                  RTC write complete
// BEHAVIOUR
//  Reset: all data regs 0, in_port 0, reg_we 0, event flags 0, ext_valid 0, commit_done 0,
//   commit_req 0, FSM IDLE, sync flops 0.
//  CPU write: write_strobe & port_id==BASE_ADDR+i (i<NUM_REGS) -> reg i <= out_port next edge;
//   reg_we[i] =1 for exactly the following cycle. Writes to unmapped ids ignored.
//  ext_load: all regs <= ext_data next edge, ext_valid <= 1. Same-cycle CPU write to reg i wins for
//   reg i only; other regs take ext_data. reg_we not asserted by ext_load.
//  Buttons: 2-flop synchroniser, then rising-edge detect; edge sets event flag bit b (sticky).
//  Read path: in_port <= mux(port_id) every cycle (1-cycle latency, independent of read_strobe):
//   BASE_ADDR+i -> reg i; BTN_ADDR -> {0, flags}; STAT_ADDR -> {5'b0, commit_busy, commit_done,
//   ext_valid}; unmapped -> 8'h00.
//  Clear-on-read: read_strobe & port_id==BTN_ADDR clears flags set at that cycle; an edge arriving in
//   the same cycle remains set. read_strobe & port_id==STAT_ADDR clears ext_valid and commit_done
//   (a same-cycle ext_load / ack sets them again).
//  Commit FSM: IDLE -> REQ when write_strobe & port_id==CTRL_ADDR & out_port[0]; commit_done <= 0.
//   REQ: commit_req=1 (registered), commit_busy=1; stays until commit_ack=1 -> WAIT_LOW, commit_done<=1.
//   WAIT_LOW: commit_req=0; back to IDLE when commit_ack=0. Commit writes in REQ/WAIT_LOW ignored.
//   out_port[1]=1 on CTRL write aborts: any state -> IDLE, commit_req 0, done unchanged.
//  Reset mid-handshake: FSM to IDLE, commit_req drops next edge regardless of commit_ack.
// TESTING
//  1 Write 8'h59 to BASE_ADDR+3 -> reg 3 =8'h59 next cycle, reg_we=9'b000001000 one cycle, others 0.
//  2 ext_load with reg i =i+1, CPU write 8'hAA to reg 0 same cycle -> reg0=AA, reg1..8=2..9,
//    status read = 8'h01, second status read = 8'h00.
//  3 btn[2] pulse 5 cycles -> BTN read = 8'h04; re-read = 8'h00; edge during read cycle survives.
//  4 CTRL write 8'h01 -> commit_req 1 next cycle; ack after 10 cycles -> req 0, status 8'h02;
//    second CTRL write while ack high ignored.
//  5 reset asserted while commit_req=1, ack=0 -> commit_req 0, all regs/in_port 0 next cycle.
//  6 Read unmapped port_id 8'hFF -> in_port 8'h00; NUM_REGS=4 build: BASE_ADDR+5 write ignored.

Source files
------------

// File: rtl/picoblaze_port_bank.sv
// PicoBlaze I/O port bank.
// Holds NUM_REGS read/write data registers, a sticky button-event register,
// a status register and the commit handshake toward the RTC controller.
module picoblaze_port_bank #(
  parameter int          NUM_REGS  = 9,
  parameter int          DATA_W    = 8,
  parameter logic [7:0]  BASE_ADDR = 8'h10,
  parameter int          BTN_N     = 4,
  parameter logic [7:0]  BTN_ADDR  = 8'h01,
  parameter logic [7:0]  STAT_ADDR = 8'h02,
  parameter logic [7:0]  CTRL_ADDR = 8'h03
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [7:0]                   port_id_i,
  input  logic                         write_strobe_i,
  input  logic                         read_strobe_i,
  input  logic [DATA_W-1:0]            out_port_i,
  output logic [DATA_W-1:0]            in_port_o,
  input  logic [BTN_N-1:0]             btn_i,
  input  logic                         ext_load_i,
  input  logic [NUM_REGS*DATA_W-1:0]   ext_data_i,
  output logic [NUM_REGS*DATA_W-1:0]   reg_data_o,
  output logic [NUM_REGS-1:0]          reg_we_o,
  output logic                         commit_req_o,
  input  logic                         commit_ack_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_LOW = 2'd2
  } commit_state_e;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] reg_we_q;
  logic [DATA_W-1:0]   in_port_q;
  logic [DATA_W-1:0]   in_port_d;

  logic [BTN_N-1:0]    btn_meta_q;
  logic [BTN_N-1:0]    btn_sync_q;
  logic [BTN_N-1:0]    btn_prev_q;
  logic [BTN_N-1:0]    btn_rise;
  logic [BTN_N-1:0]    flags_q;
  logic [BTN_N-1:0]    flags_d;

  logic                ext_valid_q;
  logic                ext_valid_d;
  logic                commit_done_q;
  logic                commit_req_q;
  logic                commit_busy;
  commit_state_e       state_q;

  logic                btn_rd;
  logic                stat_rd;
  logic                ctrl_wr;

  assign btn_rd      = read_strobe_i  && (port_id_i == BTN_ADDR);
  assign stat_rd     = read_strobe_i  && (port_id_i == STAT_ADDR);
  assign ctrl_wr     = write_strobe_i && (port_id_i == CTRL_ADDR);
  assign commit_busy = (state_q == REQ);

  // Decode CPU writes into a one-hot register select
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (write_strobe_i && (port_id_i == 8'(int'(BASE_ADDR) + i))) begin
        wr_hit[i] = 1'b1;
      end
    end
  end

  // Next register contents: a CPU write beats an RTC bulk load for its own register only
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_hit[i]) begin
        regs_d[i] = out_port_i;
      end else if (ext_load_i) begin
        regs_d[i] = ext_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Data registers and the write-notify pulse
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      reg_we_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      reg_we_q <= wr_hit;
    end
  end

  // Rising edges seen after synchronisation; a read clears old flags but not a fresh edge
  always_comb begin
    btn_rise    = btn_sync_q & ~btn_prev_q;
    flags_d     = (btn_rd ? '0 : flags_q) | btn_rise;
    ext_valid_d = (stat_rd ? 1'b0 : ext_valid_q) | ext_load_i;
  end

  // Button synchroniser, edge history, sticky event flags and RTC load flag
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      btn_meta_q  <= '0;
      btn_sync_q  <= '0;
      btn_prev_q  <= '0;
      flags_q     <= '0;
      ext_valid_q <= 1'b0;
    end else begin
      btn_meta_q  <= btn_i;
      btn_sync_q  <= btn_meta_q;
      btn_prev_q  <= btn_sync_q;
      flags_q     <= flags_d;
      ext_valid_q <= ext_valid_d;
    end
  end

  // Commit handshake toward the RTC; abort takes priority over everything else
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      commit_req_q  <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      if (stat_rd) begin
        commit_done_q <= 1'b0;
      end
      if (ctrl_wr && out_port_i[1]) begin
        state_q      <= IDLE;
        commit_req_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ctrl_wr && out_port_i[0]) begin
              state_q       <= REQ;
              commit_req_q  <= 1'b1;
              commit_done_q <= 1'b0;
            end
          end
          REQ: begin
            if (commit_ack_i) begin
              state_q       <= WAIT_LOW;
              commit_req_q  <= 1'b0;
              commit_done_q <= 1'b1;
            end
          end
          WAIT_LOW: begin
            if (!commit_ack_i) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q      <= IDLE;
            commit_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read-data mux selected by port_id; unmapped ids read as zero
  always_comb begin
    in_port_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (port_id_i == 8'(int'(BASE_ADDR) + i)) begin
        in_port_d = regs_q[i];
      end
    end
    if (port_id_i == BTN_ADDR) begin
      in_port_d = '0;
      in_port_d[BTN_N-1:0] = flags_q;
    end
    if (port_id_i == STAT_ADDR) begin
      in_port_d = '0;
      in_port_d[2:0] = {commit_busy, commit_done_q, ext_valid_q};
    end
  end

  // Registered read data, refreshed every cycle regardless of read_strobe
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_port_q <= '0;
    end else begin
      in_port_q <= in_port_d;
    end
  end

  // Flatten the register array onto the output bus
  always_comb begin
    reg_data_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_data_o[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign in_port_o    = in_port_q;
  assign reg_we_o     = reg_we_q;
  assign commit_req_o = commit_req_q;

endmodule

// File: tb/tb_picoblaze_port_bank.sv
// Self-checking bench for picoblaze_port_bank: a 9-register build plus a 4-register build
// sharing the same CPU bus, with a scoreboard queue for the registered read path.
module tb_picoblaze_port_bank;

  logic        clk;
  logic        reset;
  logic [7:0]  portId;
  logic        writeStrobe;
  logic        readStrobe;
  logic [7:0]  outPort;
  logic [7:0]  inPort;
  logic [3:0]  btn;
  logic        extLoad;
  logic [71:0] extData;
  logic [71:0] regData;
  logic [8:0]  regWe;
  logic        commitReq;
  logic        commitAck;

  logic [7:0]  inPort4;
  logic [31:0] extData4;
  logic [31:0] regData4;
  logic [3:0]  regWe4;
  logic        commitReq4;

  int checks;
  int failures;

  typedef struct {
    string      tag;
    logic [7:0] value;
  } rd_exp_t;

  rd_exp_t expQ[$];

  picoblaze_port_bank dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .port_id_i      (portId),
    .write_strobe_i (writeStrobe),
    .read_strobe_i  (readStrobe),
    .out_port_i     (outPort),
    .in_port_o      (inPort),
    .btn_i          (btn),
    .ext_load_i     (extLoad),
    .ext_data_i     (extData),
    .reg_data_o     (regData),
    .reg_we_o       (regWe),
    .commit_req_o   (commitReq),
    .commit_ack_i   (commitAck)
  );

  picoblaze_port_bank #(.NUM_REGS(4)) dut4 (
    .clk_i          (clk),
    .reset_i        (reset),
    .port_id_i      (portId),
    .write_strobe_i (writeStrobe),
    .read_strobe_i  (readStrobe),
    .out_port_i     (outPort),
    .in_port_o      (inPort4),
    .btn_i          (btn),
    .ext_load_i     (extLoad),
    .ext_data_i     (extData4),
    .reg_data_o     (regData4),
    .reg_we_o       (regWe4),
    .commit_req_o   (commitReq4),
    .commit_ack_i   (commitAck)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // One CPU write cycle
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
    portId      = addr;
    outPort     = data;
    writeStrobe = 1'b1;
    tick();
    writeStrobe = 1'b0;
  endtask

  // One CPU read cycle; the expected value is queued now and compared when in_port updates
  task automatic readPort(input string tag, input logic [7:0] addr, input logic [7:0] expected);
    rd_exp_t e;
    portId     = addr;
    readStrobe = 1'b1;
    e.tag      = tag;
    e.value    = expected;
    expQ.push_back(e);
    tick();
    readStrobe = 1'b0;
    e = expQ.pop_front();
    checkOutput(e.tag, {120'd0, inPort}, {120'd0, e.value});
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    portId      = 8'h00;
    writeStrobe = 1'b0;
    readStrobe  = 1'b0;
    outPort     = 8'h00;
    btn         = 4'h0;
    extLoad     = 1'b0;
    extData     = '0;
    extData4    = '0;
    commitAck   = 1'b0;

    tick();
    tick();
    checkOutput("rstRegData", {56'd0, regData}, 128'd0);
    checkOutput("rstInPort",  {120'd0, inPort}, 128'd0);
    checkOutput("rstRegWe",   {119'd0, regWe}, 128'd0);
    checkOutput("rstReq",     {127'd0, commitReq}, 128'd0);
    reset = 1'b0;
    tick();

    // Single CPU write to register 3
    applyStimulus(8'h13, 8'h59);
    portId = 8'h00;
    checkOutput("wrRegData", {56'd0, regData}, {56'd0, 72'h59 << 24});
    checkOutput("wrRegWe",   {119'd0, regWe}, {119'd0, 9'b000001000});
    tick();
    checkOutput("wrRegWeOff", {119'd0, regWe}, 128'd0);

    // Bulk RTC load colliding with a CPU write to register 0
    for (int i = 0; i < 9; i++) extData[i*8 +: 8] = 8'(i + 1);
    extLoad = 1'b1;
    applyStimulus(8'h10, 8'hAA);
    extLoad = 1'b0;
    checkOutput("loadRegData", {56'd0, regData}, {56'd0, 72'h0908070605040302AA});
    checkOutput("loadRegWe",   {119'd0, regWe}, {119'd0, 9'b000000001});
    readPort("statAfterLoad", 8'h02, 8'h01);
    readPort("statReread",    8'h02, 8'h00);
    readPort("readReg5",      8'h15, 8'h06);

    // Button pulse, clear-on-read, and an edge landing in the read cycle
    btn = 4'b0100;
    repeat (5) tick();
    btn = 4'b0000;
    repeat (3) tick();
    readPort("btnRead",   8'h01, 8'h04);
    readPort("btnReread", 8'h01, 8'h00);
    btn = 4'b0010;
    tick();
    tick();
    readPort("btnEdgeInRead", 8'h01, 8'h00);
    readPort("btnSurvived",   8'h01, 8'h02);
    btn = 4'b0000;
    repeat (3) tick();

    // Commit handshake with a late acknowledge
    applyStimulus(8'h03, 8'h01);
    checkOutput("commitReqSet", {127'd0, commitReq}, 128'd1);
    readPort("statBusy", 8'h02, 8'h04);
    repeat (9) tick();
    checkOutput("commitReqHeld", {127'd0, commitReq}, 128'd1);
    commitAck = 1'b1;
    tick();
    checkOutput("commitReqDrop", {127'd0, commitReq}, 128'd0);
    applyStimulus(8'h03, 8'h01);
    checkOutput("commitIgnored", {127'd0, commitReq}, 128'd0);
    readPort("statDone",   8'h02, 8'h02);
    readPort("statDoneClr", 8'h02, 8'h00);
    commitAck = 1'b0;
    tick();

    // Abort while requesting
    applyStimulus(8'h03, 8'h01);
    checkOutput("abortReqSet", {127'd0, commitReq}, 128'd1);
    applyStimulus(8'h03, 8'h02);
    checkOutput("abortReqDrop", {127'd0, commitReq}, 128'd0);
    readPort("statAbort", 8'h02, 8'h00);

    // Reset in the middle of a handshake
    applyStimulus(8'h03, 8'h01);
    checkOutput("midReqSet", {127'd0, commitReq}, 128'd1);
    readPort("preRstReg0", 8'h10, 8'hAA);
    portId = 8'h10;
    reset  = 1'b1;
    tick();
    checkOutput("midRstReq",     {127'd0, commitReq}, 128'd0);
    checkOutput("midRstRegData", {56'd0, regData}, 128'd0);
    checkOutput("midRstInPort",  {120'd0, inPort}, 128'd0);
    reset = 1'b0;
    tick();

    // Unmapped addresses on both builds
    readPort("unmappedRead", 8'hFF, 8'h00);
    applyStimulus(8'h13, 8'h33);
    applyStimulus(8'h15, 8'h77);
    portId = 8'h00;
    checkOutput("small4RegData", {96'd0, regData4}, {96'd0, 32'h33000000});
    checkOutput("small4RegWe",   {124'd0, regWe4}, 128'd0);
    checkOutput("big9RegWe",     {119'd0, regWe}, {119'd0, 9'b000100000});
    checkOutput("big9RegData",   {56'd0, regData}, {56'd0, 72'h7700_3300_0000});
    applyStimulus(8'h19, 8'h55);
    portId = 8'h00;
    checkOutput("big9Unmapped",  {56'd0, regData}, {56'd0, 72'h7700_3300_0000});
    checkOutput("big9UnmappedWe", {119'd0, regWe}, 128'd0);
    readPort("readBackReg5", 8'h15, 8'h77);

    checkOutput("scoreboardEmpty", 128'(expQ.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
